clla_adder_m: RTL and testbench
===============================

# clla_adder_m

4-bit carry-lookahead adder with a registered result stage. It computes F = A + B + Cin with all carries formed in parallel from generate/propagate terms, with no ripple chain. The sum and carry-out are captured in output registers. It is the basic arithmetic slice of the datapath and is intended for cascading into wider adders through its carry-out and optional group generate/propagate outputs.

## Interface
Parameters:
- None. Width is fixed at 4 bits.

Ports:
- `clk`  input  1  — single clock; all outputs are registered on its rising edge.
- `rst_n`  input  1  — asynchronous, active-low reset.
- `A`  input  4  — operand A, unsigned.
- `B`  input  4  — operand B, unsigned.
- `Cin`  input  1  — carry-in into bit 0.
- `F`  output  4  — registered sum bits [3:0].
- `Cout`  output  1  — registered carry-out of bit 3.
- `Gout`  output  1  — registered group generate. Present only with `CLLA_GROUP_PG_EN`.
- `Pout`  output  1  — registered group propagate. Present only with `CLLA_GROUP_PG_EN`.

## Operation
Per-bit terms:
- gi = Ai & Bi
- pi = Ai ^ Bi

Carries, each flattened to two-level sum-of-products. No cN may be built from a previous cN term.
- c0 = Cin
- c1 = g0 | p0c0
- c2 = g1 | p1g0 | p1p0c0
- c3 = g2 | p2g1 | p2p1g0 | p2p1p0c0
- c4 = g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0c0

Results:
- Sum: Fi = pi ^ ci.
- Cout = c4.
- Arithmetic is unsigned modulo 16. {Cout, F} equals the 5-bit value A + B + Cin exactly, with range 0..31.
- No overflow flag and no signed interpretation.

Group terms (only with `CLLA_GROUP_PG_EN`):
- G = g3 | p3g2 | p3p2g1 | p3p2p1g0
- P = p3p2p1p0
- Invariant: c4 = G | P&Cin.

## Timing
- Latency: 1 clock. Inputs sampled at rising edge k appear on F/Cout (and Gout/Pout) after edge k.
- The outputs are held until the next rising edge. They never glitch between edges.
- The combinational path A/B/Cin → register D fits within one clock period.
- Reset:
  - When rst_n goes low, F=4'h0, Cout=0, Gout=0 and Pout=0 immediately, with no clock needed.
  - Outputs stay zero while rst_n is low, regardless of A/B/Cin.
  - Reset mid-operation discards the in-flight result.
  - After rst_n rises, the first rising edge with rst_n high captures the current inputs.
- Input changes between edges have no effect on the outputs until the next edge.
- No handshake or valid signal. Every cycle produces a result.

## Configuration
- `CLLA_GROUP_PG_EN` defined: `Gout` and `Pout` ports exist. They are registered, reset and latency-aligned with F/Cout, for use by a second-level lookahead unit.
- `CLLA_GROUP_PG_EN` undefined: `Gout`/`Pout` and their registers are absent. F/Cout behaviour is identical in both builds.

## Test plan
- Reset: hold rst_n=0 with A=8, B=8, Cin=1 and clock running → F=0, Cout=0 (Gout=Pout=0). Release reset, then one edge → F=1, Cout=1.
- Basic sums, checked one edge after each apply:
  - 0+0+0 → F=0, Cout=0
  - 1+0+0 → F=1, Cout=0
  - 0+1+0 → F=1, Cout=0
  - 1+1+0 → F=2, Cout=0
  - 2+1+0 → F=3, Cout=0
  - 1+1+1 → F=3, Cout=0
- Carry out: A=8, B=8, Cin=1 → F=1, Cout=1. With the macro: G=1, P=0.
- Full propagate: A=15, B=0, Cin=1 → F=0, Cout=1. With the macro: G=0, P=1. A=15, B=0, Cin=0 → F=15, Cout=0.
- Latency and mid-cycle changes:
  - Change A/B/Cin twice between edges → outputs reflect only the values present at the next edge.
  - Assert rst_n low mid-cycle → outputs go to 0 before the next edge.
- Exhaustive: all 512 (A, B, Cin) combinations → {Cout, F} == A+B+Cin. With the macro, also Cout == G | (P & Cin).

Source files
------------

// File: rtl/clla_adder_m_if.sv
// Operand/result bundle for the 4-bit carry-lookahead adder slice.
// Gout/Pout exist only when CLLA_GROUP_PG_EN is defined.
interface clla_adder_m_if;
   logic [3:0] A;
   logic [3:0] B;
   logic       Cin;
   logic [3:0] F;
   logic       Cout;
`ifdef CLLA_GROUP_PG_EN
   logic       Gout;
   logic       Pout;
`endif

`ifdef CLLA_GROUP_PG_EN
   modport master (output A, output B, output Cin, input F, input Cout, input Gout, input Pout);
   modport slave  (input A, input B, input Cin, output F, output Cout, output Gout, output Pout);
`else
   modport master (output A, output B, output Cin, input F, input Cout);
   modport slave  (input A, input B, input Cin, output F, output Cout);
`endif
endinterface

// File: rtl/clla_adder_m.sv
// 4-bit carry-lookahead adder with registered sum/carry-out.
// Optional group generate/propagate outputs under CLLA_GROUP_PG_EN.
module clla_adder_m (
   input  logic           clk,
   input  logic           rst_n,
   clla_adder_m_if.slave  bus
);

   localparam int unsigned W = 4;

   logic [W-1:0] g;
   logic [W-1:0] p;
   logic [W:0]   c;
   logic [W-1:0] sum_d;
   logic [W-1:0] sum_q;
   logic         cout_d;
   logic         cout_q;

   // Every carry is a flat sum-of-products of g/p/Cin; none reuses a lower carry.
   always_comb begin
      g = bus.A & bus.B;
      p = bus.A ^ bus.B;
      c = '0;
      c[0] = bus.Cin;
      c[1] = g[0]
           | (p[0] & bus.Cin);
      c[2] = g[1]
           | (p[1] & g[0])
           | (p[1] & p[0] & bus.Cin);
      c[3] = g[2]
           | (p[2] & g[1])
           | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & bus.Cin);
      c[4] = g[3]
           | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & bus.Cin);
      sum_d  = p ^ c[W-1:0];
      cout_d = c[W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   assign bus.F    = sum_q;
   assign bus.Cout = cout_q;

`ifdef CLLA_GROUP_PG_EN
   logic grp_g_d;
   logic grp_p_d;
   logic grp_g_q;
   logic grp_p_q;

   // Group terms for a second-level lookahead unit: c4 == G | (P & Cin).
   always_comb begin
      grp_g_d = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
      grp_p_d = p[3] & p[2] & p[1] & p[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grp_g_q <= 1'b0;
         grp_p_q <= 1'b0;
      end else begin
         grp_g_q <= grp_g_d;
         grp_p_q <= grp_p_d;
      end
   end

   assign bus.Gout = grp_g_q;
   assign bus.Pout = grp_p_q;
`endif

endmodule

// File: tb/tb_clla_adder_m.sv
// Directed bench for clla_adder_m; define CLLA_GROUP_PG_EN to also cover Gout/Pout.
module tb_clla_adder_m;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   clla_adder_m_if bus ();

   clla_adder_m dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive operands, then sample 1 time unit after the capturing edge.
   task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic ci);
      bus.A   = a;
      bus.B   = b;
      bus.Cin = ci;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.A = 4'd8; bus.B = 4'd8; bus.Cin = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if (bus.F !== 4'h0) $display("FAIL reset_F got=%h exp=0", bus.F); else n_pass++;
      n_total++;
      if (bus.Cout !== 1'b0) $display("FAIL reset_Cout got=%b exp=0", bus.Cout); else n_pass++;
`ifdef CLLA_GROUP_PG_EN
      n_total++;
      if ({bus.Gout, bus.Pout} !== 2'b00)
         $display("FAIL reset_GP got=%b%b exp=00", bus.Gout, bus.Pout);
      else n_pass++;
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_total++;
      if ({bus.Cout, bus.F} !== 5'h11)
         $display("FAIL reset_release got=%h exp=11", {bus.Cout, bus.F});
      else n_pass++;
   endtask

   task automatic test_basic;
      logic [3:0] va [6] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd2, 4'd1};
      logic [3:0] vb [6] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1};
      logic       vc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [3:0] ef [6] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd3};
      for (int i = 0; i < 6; i++) begin
         apply(va[i], vb[i], vc[i]);
         n_total++;
         if (bus.F !== ef[i] || bus.Cout !== 1'b0)
            $display("FAIL basic_%0d got=%b/%h exp=0/%h", i, bus.Cout, bus.F, ef[i]);
         else n_pass++;
      end
   endtask

   task automatic test_carry;
      apply(4'd8, 4'd8, 1'b1);
      n_total++;
      if ({bus.Cout, bus.F} !== 5'h11)
         $display("FAIL carry_out got=%h exp=11", {bus.Cout, bus.F});
      else n_pass++;
`ifdef CLLA_GROUP_PG_EN
      n_total++;
      if ({bus.Gout, bus.Pout} !== 2'b10)
         $display("FAIL carry_GP got=%b%b exp=10", bus.Gout, bus.Pout);
      else n_pass++;
`endif
   endtask

   task automatic test_propagate;
      apply(4'd15, 4'd0, 1'b1);
      n_total++;
      if ({bus.Cout, bus.F} !== 5'h10)
         $display("FAIL prop_cin1 got=%h exp=10", {bus.Cout, bus.F});
      else n_pass++;
`ifdef CLLA_GROUP_PG_EN
      n_total++;
      if ({bus.Gout, bus.Pout} !== 2'b01)
         $display("FAIL prop_GP got=%b%b exp=01", bus.Gout, bus.Pout);
      else n_pass++;
`endif
      apply(4'd15, 4'd0, 1'b0);
      n_total++;
      if ({bus.Cout, bus.F} !== 5'h0F)
         $display("FAIL prop_cin0 got=%h exp=0f", {bus.Cout, bus.F});
      else n_pass++;
   endtask

   task automatic test_latency;
      apply(4'd3, 4'd4, 1'b0);
      bus.A = 4'd9; bus.B = 4'd9; bus.Cin = 1'b1;
      #2;
      bus.A = 4'd5; bus.B = 4'd6; bus.Cin = 1'b1;
      #1;
      n_total++;
      if ({bus.Cout, bus.F} !== 5'h07)
         $display("FAIL latency_hold got=%h exp=07", {bus.Cout, bus.F});
      else n_pass++;
      @(posedge clk);
      #1;
      n_total++;
      if ({bus.Cout, bus.F} !== 5'h0C)
         $display("FAIL latency_last got=%h exp=0c", {bus.Cout, bus.F});
      else n_pass++;
   endtask

   task automatic test_midcycle_reset;
      apply(4'd8, 4'd8, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({bus.Cout, bus.F} !== 5'h00)
         $display("FAIL async_reset got=%h exp=00", {bus.Cout, bus.F});
      else n_pass++;
      @(posedge clk);
      #1;
      n_total++;
      if ({bus.Cout, bus.F} !== 5'h00)
         $display("FAIL reset_hold got=%h exp=00", {bus.Cout, bus.F});
      else n_pass++;
      rst_n = 1'b1;
   endtask

   task automatic test_exhaustive;
      int errs;
      logic [4:0] exp_sum;
      errs = 0;
      for (int v = 0; v < 512; v++) begin
         logic [3:0] a;
         logic [3:0] b;
         logic       ci;
         a  = 4'(v >> 5);
         b  = 4'(v >> 1);
         ci = 1'(v);
         apply(a, b, ci);
         exp_sum = 5'({1'b0, a} + {1'b0, b} + {4'b0, ci});
         n_total++;
         if ({bus.Cout, bus.F} !== exp_sum) begin
            errs++;
            if (errs < 8)
               $display("FAIL exh_sum a=%h b=%h ci=%b got=%h exp=%h", a, b, ci, {bus.Cout, bus.F}, exp_sum);
         end else n_pass++;
`ifdef CLLA_GROUP_PG_EN
         begin
            logic eg;
            logic ep;
            eg = (5'({1'b0, a} + {1'b0, b}) >= 5'd16);
            ep = ((a ^ b) == 4'hF);
            n_total++;
            if (bus.Gout !== eg || bus.Pout !== ep || bus.Cout !== (bus.Gout | (bus.Pout & ci))) begin
               errs++;
               if (errs < 8)
                  $display("FAIL exh_gp a=%h b=%h ci=%b got=%b%b exp=%b%b", a, b, ci, bus.Gout, bus.Pout, eg, ep);
            end else n_pass++;
         end
`endif
      end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst_n   = 1'b0;
      bus.A   = '0;
      bus.B   = '0;
      bus.Cin = 1'b0;
      test_reset();
      test_basic();
      test_carry();
      test_propagate();
      test_latency();
      test_midcycle_reset();
      test_exhaustive();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
